vec_max_n: RTL and testbench

Parametrised successor to the 3-lane vec_max reduction. It reduces N_LANES IEEE-754 single-precision lanes to one extreme value, either max or min, selected per sample. It returns the value, the winning lane index and a NaN flag. The block is a fully pipelined comparison tree with valid/ready backpressure and sits between the vector float stages and downstream consumers of the ray/vector pipeline.

---
 rtl/vec_max_n.sv | 116 +++++++++++
 tb/tb_vec_max_n.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_max_n.sv
// N-lane binary32 max/min reduction: registered input stage, then a pipelined
// pairwise comparison tree with valid/ready backpressure and NaN tracking.
module vec_max_n #(
   parameter  int N_LANES = 3,
   localparam int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1,
   localparam int LEVELS  = $clog2(N_LANES)
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [32*N_LANES-1:0]   v_in,
   input  logic                    mode_in,
   input  logic                    v_valid_in,
   output logic                    v_ready_out,
   output logic [31:0]             res_data_out,
   output logic [IDX_W-1:0]        res_idx_out,
   output logic                    res_nan_out,
   output logic                    res_valid_out,
   input  logic                    res_ready_in
);

   typedef struct packed {
      logic             nan;
      logic [IDX_W-1:0] idx;
      logic [31:0]      data;
   } node_t;

   function automatic int cnt_at(input int l);
      return (N_LANES + (1 << l) - 1) >> l;
   endfunction

   function automatic int off_at(input int l);
      int s;
      s = 0;
      for (int k = 0; k < l; k++) s += cnt_at(k);
      return s;
   endfunction

   localparam int          TOTAL = off_at(LEVELS + 1);
   localparam int          MW    = (LEVELS > 0) ? LEVELS : 1;
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   // Monotonic unsigned key: total order with -0 < +0 and -inf/+inf at the ends.
   function automatic logic [31:0] sort_key(input logic [31:0] x);
      return x[31] ? ~x : (x | 32'h8000_0000);
   endfunction

   // a always carries the lower lane indices, so ties and NaN precedence favour it.
   function automatic node_t pick(input node_t a, input node_t b, input logic min_mode);
      logic b_wins;
      if (a.nan)         b_wins = 1'b0;
      else if (b.nan)    b_wins = 1'b1;
      else if (min_mode) b_wins = sort_key(b.data) < sort_key(a.data);
      else               b_wins = sort_key(b.data) > sort_key(a.data);
      return b_wins ? b : a;
   endfunction

   node_t [TOTAL-1:0] node_d, node_q;
   logic  [MW-1:0]    mode_d, mode_q;
   logic  [LEVELS:0]  vld_d, vld_q;
   logic              en;

   assign en          = !vld_q[LEVELS] || res_ready_in;
   assign v_ready_out = en;

   always_comb begin
      logic [31:0] lane;
      logic        lane_nan;
      lane     = '0;
      lane_nan = 1'b0;
      node_d   = node_q;
      mode_d   = mode_q;
      vld_d    = vld_q;
      vld_d[0]  = v_valid_in;
      mode_d[0] = mode_in;
      // NaN lanes are canonicalised on entry so the tree only moves the flag.
      for (int i = 0; i < N_LANES; i++) begin
         lane     = v_in[32*i +: 32];
         lane_nan = (lane[30:23] == 8'hFF) && (lane[22:0] != 23'd0);
         node_d[i].nan  = lane_nan;
         node_d[i].idx  = IDX_W'(i);
         node_d[i].data = lane_nan ? QNAN : lane;
      end
      for (int l = 1; l <= LEVELS; l++) begin
         vld_d[l] = vld_q[l-1];
         if (l < LEVELS) mode_d[l] = mode_q[l-1];
         for (int j = 0; j < N_LANES; j++) begin
            if (j < cnt_at(l)) begin
               if (2*j + 1 < cnt_at(l-1))
                  node_d[off_at(l) + j] = pick(node_q[off_at(l-1) + 2*j],
                                               node_q[off_at(l-1) + 2*j + 1],
                                               mode_q[l-1]);
               else
                  node_d[off_at(l) + j] = node_q[off_at(l-1) + 2*j];
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         node_q <= '0;
         mode_q <= '0;
         vld_q  <= '0;
      end else if (en) begin
         node_q <= node_d;
         mode_q <= mode_d;
         vld_q  <= vld_d;
      end
   end

   assign res_valid_out = vld_q[LEVELS];
   assign res_data_out  = node_q[TOTAL-1].data;
   assign res_idx_out   = node_q[TOTAL-1].idx;
   assign res_nan_out   = node_q[TOTAL-1].nan;

endmodule

// File: tb/tb_vec_max_n.sv
// Scoreboard bench for vec_max_n at N_LANES = 3, 1 and 8: directed samples push
// hand-computed results; per-instance monitors pop and compare on each handshake.
module tb_vec_max_n;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  idx;
      logic        nan;
      bit          lat;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errs   = 0;

   exp_t q3[$];
   exp_t q1[$];
   exp_t q8[$];

   logic [95:0]  v3;
   logic         m3, vv3, rdy3, nan3, rv3, rr3;
   logic [31:0]  d3;
   logic [1:0]   i3;

   logic [31:0]  v1;
   logic         m1, vv1, rdy1, nan1, rv1, rr1;
   logic [31:0]  d1;
   logic [0:0]   i1;

   logic [255:0] v8;
   logic         m8, vv8, rdy8, nan8, rv8, rr8;
   logic [31:0]  d8;
   logic [2:0]   i8;

   vec_max_n #(.N_LANES(3)) dut3 (
      .clk_in(clk), .rst_n_in(rst_n), .v_in(v3), .mode_in(m3), .v_valid_in(vv3),
      .v_ready_out(rdy3), .res_data_out(d3), .res_idx_out(i3), .res_nan_out(nan3),
      .res_valid_out(rv3), .res_ready_in(rr3));

   vec_max_n #(.N_LANES(1)) dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .v_in(v1), .mode_in(m1), .v_valid_in(vv1),
      .v_ready_out(rdy1), .res_data_out(d1), .res_idx_out(i1), .res_nan_out(nan1),
      .res_valid_out(rv1), .res_ready_in(rr1));

   vec_max_n #(.N_LANES(8)) dut8 (
      .clk_in(clk), .rst_n_in(rst_n), .v_in(v8), .mode_in(m8), .v_valid_in(vv8),
      .v_ready_out(rdy8), .res_data_out(d8), .res_idx_out(i8), .res_nan_out(nan8),
      .res_valid_out(rv8), .res_ready_in(rr8));

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errs++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   function automatic void mon_check(input int sel, input logic [31:0] d, input logic [3:0] i,
                                     input logic n);
      exp_t e;
      bit   got;
      int   lat_req;
      got     = 1'b0;
      lat_req = 3;
      case (sel)
         0: begin lat_req = 3; if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end end
         1: begin lat_req = 1; if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end end
         default: begin lat_req = 4; if (q8.size() > 0) begin e = q8.pop_front(); got = 1'b1; end end
      endcase
      if (!got) begin
         n_checks++;
         n_errs++;
         $display("FAIL dut%0d_unexpected_result actual=%h required=none", sel, d);
      end else begin
         chk($sformatf("dut%0d_data", sel), d, e.data);
         chk($sformatf("dut%0d_idx", sel), {28'd0, i}, {28'd0, e.idx});
         chk($sformatf("dut%0d_nan", sel), {31'd0, n}, {31'd0, e.nan});
         if (e.lat) chk($sformatf("dut%0d_latency", sel), cyc - e.cyc, lat_req);
      end
   endfunction

   always @(negedge clk) if (rv3 && rr3) mon_check(0, d3, {2'b00, i3}, nan3);
   always @(negedge clk) if (rv1 && rr1) mon_check(1, d1, {3'b000, i1}, nan1);
   always @(negedge clk) if (rv8 && rr8) mon_check(2, d8, {1'b0, i8}, nan8);

   // Present one sample, wait (bounded) for acceptance, optionally log its expected result.
   task automatic send(input int sel, input logic [255:0] v, input logic m, input logic [31:0] ed,
                       input logic [3:0] ei, input logic en, input bit push, input bit lat);
      exp_t e;
      logic rdy;
      rdy = 1'b0;
      case (sel)
         0:       begin v3 = v[95:0]; m3 = m; vv3 = 1'b1; end
         1:       begin v1 = v[31:0]; m1 = m; vv1 = 1'b1; end
         default: begin v8 = v;       m8 = m; vv8 = 1'b1; end
      endcase
      for (int g = 0; g < 50 && !rdy; g++) begin
         @(negedge clk);
         rdy = (sel == 0) ? rdy3 : (sel == 1) ? rdy1 : rdy8;
      end
      if (!rdy) begin
         n_checks++;
         n_errs++;
         $display("FAIL dut%0d_send_timeout actual=0 required=1", sel);
      end else if (push) begin
         e.data = ed; e.idx = ei; e.nan = en; e.lat = lat; e.cyc = cyc;
         case (sel)
            0:       q3.push_back(e);
            1:       q1.push_back(e);
            default: q8.push_back(e);
         endcase
      end
      @(posedge clk);
      #1;
      vv3 = 1'b0; vv1 = 1'b0; vv8 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      v3 = '0; m3 = 1'b0; vv3 = 1'b0; rr3 = 1'b1;
      v1 = '0; m1 = 1'b0; vv1 = 1'b0; rr1 = 1'b1;
      v8 = '0; m8 = 1'b0; vv8 = 1'b0; rr8 = 1'b1;
      @(posedge clk); #2;
      chk("rst_valid", {31'd0, rv3}, 0);
      chk("rst_data",  d3, 0);
      chk("rst_idx",   {30'd0, i3}, 0);
      chk("rst_nan",   {31'd0, nan3}, 0);
      chk("rst_ready", {31'd0, rdy3}, 1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // N=3 directed samples, back to back, latency checked
      send(0, {32'h41200000, 32'h41200000, 32'h40A00000}, 1'b0, 32'h41200000, 4'd1, 1'b0, 1, 1);
      send(0, {32'h40A00000, 32'hBF800000, 32'h41700000}, 1'b1, 32'hBF800000, 4'd1, 1'b0, 1, 1);
      send(0, {32'h40A00000, 32'h80000000, 32'h00000000}, 1'b0, 32'h40A00000, 4'd2, 1'b0, 1, 1);
      send(0, {32'h40A00000, 32'h80000000, 32'h00000000}, 1'b1, 32'h80000000, 4'd1, 1'b0, 1, 1);
      send(0, {32'h7FA00000, 32'hFFC00001, 32'h7F800000}, 1'b0, 32'h7FC00000, 4'd1, 1'b1, 1, 1);
      send(0, {32'h3F800000, 32'h7F800001, 32'h7FC00000}, 1'b1, 32'h7FC00000, 4'd0, 1'b1, 1, 1);
      send(0, {32'h7F800001, 32'hFF800000, 32'h3F800000}, 1'b1, 32'h7FC00000, 4'd2, 1'b1, 1, 1);
      send(0, {32'h00000001, 32'h80000001, 32'hFF800000}, 1'b1, 32'hFF800000, 4'd0, 1'b0, 1, 1);
      send(0, {32'h00000001, 32'h80000001, 32'hFF800000}, 1'b0, 32'h00000001, 4'd2, 1'b0, 1, 1);
      send(0, {32'h80000001, 32'h00800000, 32'h00000001}, 1'b1, 32'h80000001, 4'd2, 1'b0, 1, 1);
      send(0, {32'h00000000, 32'h7F7FFFFF, 32'h7F800000}, 1'b0, 32'h7F800000, 4'd0, 1'b0, 1, 1);
      // mode toggling on consecutive cycles
      send(0, {32'h40400000, 32'h40000000, 32'h3F800000}, 1'b0, 32'h40400000, 4'd2, 1'b0, 1, 1);
      send(0, {32'h40400000, 32'h40000000, 32'h3F800000}, 1'b1, 32'h3F800000, 4'd0, 1'b0, 1, 1);
      send(0, {32'h3F800000, 32'hBF800000, 32'hC0000000}, 1'b0, 32'h3F800000, 4'd2, 1'b0, 1, 1);
      send(0, {32'h3F800000, 32'hBF800000, 32'hC0000000}, 1'b1, 32'hC0000000, 4'd0, 1'b0, 1, 1);
      repeat (6) @(posedge clk);
      #1;

      // backpressure: downstream stalls for 5 cycles once the first result is valid
      rr3 = 1'b0;
      fork
         begin
            send(0, {32'h40400000, 32'h40000000, 32'h3F800000}, 1'b0, 32'h40400000, 4'd2, 1'b0, 1, 0);
            send(0, {32'h40400000, 32'h40000000, 32'h3F800000}, 1'b1, 32'h3F800000, 4'd0, 1'b0, 1, 0);
            send(0, {32'h41200000, 32'h41200000, 32'h40A00000}, 1'b0, 32'h41200000, 4'd1, 1'b0, 1, 0);
            send(0, {32'h40A00000, 32'hBF800000, 32'h41700000}, 1'b1, 32'hBF800000, 4'd1, 1'b0, 1, 0);
         end
         begin
            logic seen;
            seen = 1'b0;
            for (int g = 0; g < 20 && !seen; g++) begin
               @(negedge clk);
               seen = rv3;
            end
            chk("bp_first_valid", {31'd0, seen}, 1);
            for (int k = 0; k < 5; k++) begin
               if (k > 0) @(negedge clk);
               chk("bp_ready_low", {31'd0, rdy3}, 0);
               chk("bp_valid_hold", {31'd0, rv3}, 1);
               chk("bp_data_hold", d3, 32'h40400000);
               chk("bp_idx_hold", {30'd0, i3}, 2);
            end
            @(posedge clk);
            #1;
            rr3 = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;

      // reset with two samples in flight: neither may ever emerge
      rr3 = 1'b0;
      send(0, {32'h40400000, 32'h40000000, 32'h3F800000}, 1'b0, 32'h0, 4'd0, 1'b0, 0, 0);
      send(0, {32'h41200000, 32'h41200000, 32'h40A00000}, 1'b0, 32'h0, 4'd0, 1'b0, 0, 0);
      @(posedge clk);
      #2;
      chk("pre_rst_valid", {31'd0, rv3}, 1);
      chk("pre_rst_data", d3, 32'h40400000);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, rv3}, 0);
      chk("async_rst_data", d3, 0);
      chk("async_rst_idx", {30'd0, i3}, 0);
      chk("async_rst_ready", {31'd0, rdy3}, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      rr3   = 1'b1;
      begin
         int stale;
         stale = 0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rv3) stale++;
         end
         chk("no_stale_after_rst", stale, 0);
      end
      @(posedge clk);
      #1;
      send(0, {32'h40A00000, 32'hBF800000, 32'h41700000}, 1'b1, 32'hBF800000, 4'd1, 1'b0, 1, 1);

      // N=1: latency 1, index always 0
      send(1, 256'h40A00000, 1'b0, 32'h40A00000, 4'd0, 1'b0, 1, 1);
      send(1, 256'h7FA00000, 1'b1, 32'h7FC00000, 4'd0, 1'b1, 1, 1);
      send(1, 256'h80000000, 1'b1, 32'h80000000, 4'd0, 1'b0, 1, 1);

      // N=8: latency 4, tie across subtrees resolved to the lower lane
      send(2, {32'hC0000000, 32'h40400000, 32'h40000000, 32'h41200000,
               32'h41200000, 32'hBF800000, 32'h40A00000, 32'h3F800000},
           1'b0, 32'h41200000, 4'd3, 1'b0, 1, 1);
      send(2, {32'hC0000000, 32'h40400000, 32'h40000000, 32'h41200000,
               32'h41200000, 32'hBF800000, 32'h40A00000, 32'h3F800000},
           1'b1, 32'hC0000000, 4'd7, 1'b0, 1, 1);
      send(2, {32'hC0000000, 32'h40400000, 32'hFFC00000, 32'h41200000,
               32'h41200000, 32'hBF800000, 32'h40A00000, 32'h3F800000},
           1'b0, 32'h7FC00000, 4'd5, 1'b1, 1, 1);

      repeat (10) @(posedge clk);
      #1;
      chk("scoreboard_drained", q3.size() + q1.size() + q8.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
